// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Fetch/decode/issue controller sitting directly upstream of the ALU. Walks a
//   program counter through a synchronous instruction ROM, decodes each word,
//   and either issues it to the ALU over a valid/ready handshake (op 0x0-0xC)
//   or executes it locally (0xD BRZ, 0xE JMP, 0xF HALT).
//
//   Instruction layout (16 bits):
//     [15:12] op   [11:8] ra   [7:4] rb   [7:0] branch/jump target   [3:0] unused
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 one-cycle pulse; runs the program from address 0
//   imem_en, imem_addr    ROM read strobe/address (data returns next cycle)
//   imem_rdata            ROM read data
//   alu_op/ra/rb          operation fields presented to the ALU
//   alu_valid, alu_ready  issue handshake
//   alu_done, alu_zero    completion pulse and zero result (qualified by done)
//   pc_out                current program counter (debug)
//   halted                high while in HALT
//
// INSTR_W is carried for interface documentation only; the field layout above
// assumes a 16-bit instruction word.
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         alu_op,
  output logic [3:0]         alu_ra,
  output logic [3:0]         alu_rb,
  output logic               alu_valid,
  input  logic               alu_ready,
  input  logic               alu_done,
  input  logic               alu_zero,
  output logic [PC_W-1:0]    pc_out,
  output logic               halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT,
    HALT
  } state_t;

  localparam logic [3:0] OP_LAST_ALU = 4'b1100;
  localparam logic [3:0] OP_BRZ      = 4'b1101;
  localparam logic [3:0] OP_JMP      = 4'b1110;

  state_t          state, stateNext;
  logic [PC_W-1:0] pc, pcNext;
  logic            zeroFlag, zeroFlagNext;
  logic            imemEn, imemEnNext;
  logic            aluValid, aluValidNext;
  logic [3:0]      aluOp, aluOpNext;
  logic [3:0]      aluRa, aluRaNext;
  logic [3:0]      aluRb, aluRbNext;
  logic            haltedQ, haltedNext;

  // Decoded fields of the word returned by the ROM (only meaningful in DECODE).
  logic [3:0]      decOp, decRa, decRb;
  logic [PC_W-1:0] decTarget;
  logic            unusedBits;

  assign decOp      = imem_rdata[15:12];
  assign decRa      = imem_rdata[11:8];
  assign decRb      = imem_rdata[7:4];
  // Size cast zero-extends or truncates the 8-bit target to the PC width.
  assign decTarget  = PC_W'(imem_rdata[7:0]);
  assign unusedBits = ^imem_rdata[3:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    stateNext    = state;
    pcNext       = pc;
    zeroFlagNext = zeroFlag;
    imemEnNext   = 1'b0;   // ROM strobe is a one-cycle pulse per fetch
    aluValidNext = aluValid;
    aluOpNext    = aluOp;
    aluRaNext    = aluRa;
    aluRbNext    = aluRb;
    haltedNext   = haltedQ;

    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          stateNext    = FETCH;
          pcNext       = '0;
          zeroFlagNext = 1'b0;
          imemEnNext   = 1'b1;
          haltedNext   = 1'b0;
        end
      end

      FETCH: stateNext = DECODE;

      DECODE: begin
        if (decOp <= OP_LAST_ALU) begin
          stateNext    = ISSUE;
          aluValidNext = 1'b1;
          aluOpNext    = decOp;
          aluRaNext    = decRa;
          aluRbNext    = decRb;
        end else if (decOp == OP_BRZ) begin
          stateNext  = FETCH;
          imemEnNext = 1'b1;
          pcNext     = zeroFlag ? decTarget : pc + PC_W'(1);
        end else if (decOp == OP_JMP) begin
          stateNext  = FETCH;
          imemEnNext = 1'b1;
          pcNext     = decTarget;
        end else begin
          stateNext  = HALT;
          haltedNext = 1'b1;
        end
      end

      // Fields are held untouched until the ALU takes the operation.
      ISSUE: begin
        if (alu_ready) begin
          stateNext    = WAIT;
          aluValidNext = 1'b0;
          pcNext       = pc + PC_W'(1);
        end
      end

      // alu_done is only honoured here; elsewhere it is ignored entirely.
      WAIT: begin
        if (alu_done) begin
          stateNext    = FETCH;
          imemEnNext   = 1'b1;
          zeroFlagNext = alu_zero;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      zeroFlag <= 1'b0;
      imemEn   <= 1'b0;
      aluValid <= 1'b0;
      aluOp    <= '0;
      aluRa    <= '0;
      aluRb    <= '0;
      haltedQ  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state    <= stateNext;
      pc       <= pcNext;
      zeroFlag <= zeroFlagNext;
      imemEn   <= imemEnNext;
      aluValid <= aluValidNext;
      aluOp    <= aluOpNext;
      aluRa    <= aluRaNext;
      aluRb    <= aluRbNext;
      haltedQ  <= haltedNext;
    end
  end

  // Every output comes straight from a flop.
  assign imem_en   = imemEn;
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign alu_valid = aluValid;
  assign alu_op    = aluOp;
  assign alu_ra    = aluRa;
  assign alu_rb    = aluRb;
  assign halted    = haltedQ;

endmodule
